// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scanout
//  Purpose  : Parametrised VGA raster generator. Issues pixel-coordinate
//             requests ahead of the beam. A PIX_LATENCY-deep pipeline re-aligns
//             sync, blanking and strobes with the colour that comes back from
//             framebuffer or sprite logic. All state advances only on ticks
//             where en=1, so the block can run from a clock faster than the
//             pixel rate.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             en              - pixel tick enable
//             color           - {r,g,b} for the pixel requested PIX_LATENCY
//                               ticks earlier
//             pix_x/pix_y     - requested coordinate (0 when not visible)
//             pix_req         - requested coordinate is visible
//             vga_r/g/b       - colour out, zero while blanked
//             vga_hsync/vsync - sync outputs with programmable polarity
//             vga_de          - display enable
//             line_start      - one-clk pulse: first pixel of a line on output
//             frame_start     - one-clk pulse: pixel (0,0) on output
//  Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned H_FPORCH    = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BPORCH    = 48,
    parameter int unsigned V_FPORCH    = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BPORCH    = 33,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned COLOR_BITS  = 4,
    parameter int unsigned PIX_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [3*COLOR_BITS-1:0]   color,
    output logic [15:0]               pix_x,
    output logic [15:0]               pix_y,
    output logic                      pix_req,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      vga_de,
    output logic                      line_start,
    output logic                      frame_start
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_FULL_LINE  = WIDTH + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int unsigned c_FULL_FRAME = HEIGHT + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [15:0] c_H_LAST   = 16'(c_FULL_LINE - 1);
    localparam logic [15:0] c_V_LAST   = 16'(c_FULL_FRAME - 1);
    localparam logic [15:0] c_WIDTH    = 16'(WIDTH);
    localparam logic [15:0] c_HEIGHT   = 16'(HEIGHT);
    localparam logic [15:0] c_HS_START = 16'(WIDTH + H_FPORCH);
    localparam logic [15:0] c_HS_END   = 16'(WIDTH + H_FPORCH + H_SYNC);
    localparam logic [15:0] c_VS_START = 16'(HEIGHT + V_FPORCH);
    localparam logic [15:0] c_VS_END   = 16'(HEIGHT + V_FPORCH + V_SYNC);

    // Flag vector carried down the alignment pipeline. Sync bits hold the
    // "active" condition, not the pin level, so an all-zero stage means
    // blank with both syncs inactive.
    localparam int c_FLAG_W = 5;
    localparam int c_F_VIS  = 4;
    localparam int c_F_HS   = 3;
    localparam int c_F_VS   = 2;
    localparam int c_F_H0   = 1;
    localparam int c_F_F0   = 0;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (c_FULL_LINE > 65535) begin : g_err_line
            $error("vga_scanout: full line length exceeds 65535");
        end
        if (c_FULL_FRAME > 65535) begin : g_err_frame
            $error("vga_scanout: full frame length exceeds 65535");
        end
        if (PIX_LATENCY > 7) begin : g_err_latency
            $error("vga_scanout: PIX_LATENCY must be 0..7");
        end
        if (COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_err_color
            $error("vga_scanout: COLOR_BITS must be 1..8");
        end
        if (H_SYNC < 1 || V_SYNC < 1) begin : g_err_sync
            $error("vga_scanout: sync pulse lengths must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (en) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == c_V_LAST) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 16'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------------
    logic                w_visible;
    logic                w_hs_act;
    logic                w_vs_act;
    logic                w_h0;
    logic                w_f0;
    logic [c_FLAG_W-1:0] w_req_flags;

    assign w_visible = (r_h_cnt < c_WIDTH) && (r_v_cnt < c_HEIGHT);
    assign w_hs_act  = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    // Depends on v_cnt only, so vsync moves on whole-line boundaries.
    assign w_vs_act  = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    assign w_h0      = (r_h_cnt == 16'd0);
    assign w_f0      = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);

    assign w_req_flags = {w_visible, w_hs_act, w_vs_act, w_h0, w_f0};

    assign pix_req = w_visible && !rst;
    assign pix_x   = w_visible ? r_h_cnt : 16'd0;
    assign pix_y   = w_visible ? r_v_cnt : 16'd0;

    // ------------------------------------------------------------------------
    // Alignment pipeline: delays the request flags by PIX_LATENCY enabled
    // ticks so they meet the colour returned for the same coordinate.
    // ------------------------------------------------------------------------
    logic [c_FLAG_W-1:0] w_last_flags;

    generate
        if (PIX_LATENCY > 0) begin : g_pipe
            logic [c_FLAG_W-1:0] r_stage [PIX_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIX_LATENCY; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (en) begin
                    r_stage[0] <= w_req_flags;
                    for (int i = 1; i < PIX_LATENCY; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_last_flags = r_stage[PIX_LATENCY-1];
        end else begin : g_bypass
            // Zero latency: colour is sampled in the same tick the
            // coordinate is presented.
            assign w_last_flags = w_req_flags;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    logic [COLOR_BITS-1:0] w_col_r;
    logic [COLOR_BITS-1:0] w_col_g;
    logic [COLOR_BITS-1:0] w_col_b;
    logic                  w_out_vis;

    assign w_col_r   = color[3*COLOR_BITS-1 -: COLOR_BITS];
    assign w_col_g   = color[2*COLOR_BITS-1 -: COLOR_BITS];
    assign w_col_b   = color[COLOR_BITS-1:0];
    assign w_out_vis = w_last_flags[c_F_VIS];

    logic [COLOR_BITS-1:0] r_vga_r;
    logic [COLOR_BITS-1:0] r_vga_g;
    logic [COLOR_BITS-1:0] r_vga_b;
    logic                  r_vga_hsync;
    logic                  r_vga_vsync;
    logic                  r_vga_de;
    logic                  r_line_start;
    logic                  r_frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_vga_hsync   <= ~HSYNC_POL;
            r_vga_vsync   <= ~VSYNC_POL;
            r_vga_de      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes last one clk after the enabled tick that loads the
            // flagged position; every other cycle they are low.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (en) begin
                r_vga_de      <= w_out_vis;
                r_vga_r       <= w_out_vis ? w_col_r : '0;
                r_vga_g       <= w_out_vis ? w_col_g : '0;
                r_vga_b       <= w_out_vis ? w_col_b : '0;
                r_vga_hsync   <= w_last_flags[c_F_HS] ? HSYNC_POL : ~HSYNC_POL;
                r_vga_vsync   <= w_last_flags[c_F_VS] ? VSYNC_POL : ~VSYNC_POL;
                r_line_start  <= w_last_flags[c_F_H0];
                r_frame_start <= w_last_flags[c_F_F0];
            end
        end
    end

    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign vga_hsync   = r_vga_hsync;
    assign vga_vsync   = r_vga_vsync;
    assign vga_de      = r_vga_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scanout
//  Purpose  : Self-checking bench for vga_scanout on a small 8x4 raster.
//             A reference raster model pushes the expected output word for
//             every enabled tick into a queue; the word is popped when the
//             DUT output register is due to show it. A delayed memory model
//             returns {x,y,5} for visible requests and 12'hFFF otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int c_W     = 8;
    localparam int c_H     = 4;
    localparam int c_HFP   = 2;
    localparam int c_HS    = 3;
    localparam int c_HBP   = 1;
    localparam int c_VFP   = 1;
    localparam int c_VS    = 2;
    localparam int c_VBP   = 1;
    localparam int c_LINE  = 14;
    localparam int c_FRAME = 8;
    localparam int c_LAT   = 2;
    localparam int c_CB    = 4;
    localparam bit c_HPOL  = 1'b0;
    localparam bit c_VPOL  = 1'b1;

    typedef struct packed {
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [11:0] color;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_req;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic        line_start;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_scanout #(
        .WIDTH      (c_W),
        .HEIGHT     (c_H),
        .H_FPORCH   (c_HFP),
        .H_SYNC     (c_HS),
        .H_BPORCH   (c_HBP),
        .V_FPORCH   (c_VFP),
        .V_SYNC     (c_VS),
        .V_BPORCH   (c_VBP),
        .HSYNC_POL  (c_HPOL),
        .VSYNC_POL  (c_VPOL),
        .COLOR_BITS (c_CB),
        .PIX_LATENCY(c_LAT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .color      (color),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_req    (pix_req),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_de     (vga_de),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    // ------------------------------------------------------------------------
    // Memory model: c_LAT enabled-tick delay, blank region returns all ones
    // ------------------------------------------------------------------------
    logic        force_ff;
    logic [11:0] mem_q [c_LAT];
    wire  [11:0] w_mem_in = pix_req ? {pix_x[3:0], pix_y[3:0], 4'h5} : 12'hFFF;

    always @(posedge clk) begin
        if (en) begin
            mem_q[0] <= w_mem_in;
            for (int i = 1; i < c_LAT; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign color = force_ff ? 12'hFFF : mem_q[c_LAT-1];

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference raster model and scoreboard
    // ------------------------------------------------------------------------
    int   mh = 0;
    int   mv = 0;
    int   cyc = 0;
    bit   started = 1'b0;
    out_t exp_out;
    out_t sb_q[$];

    function automatic out_t blank_out();
        out_t o;
        o    = '0;
        o.hs = ~c_HPOL;
        o.vs = ~c_VPOL;
        return o;
    endfunction

    function automatic out_t pos_out(input int h, input int v);
        out_t        o;
        logic [15:0] hx;
        logic [15:0] vx;
        logic        vis;
        hx   = 16'(h);
        vx   = 16'(v);
        vis  = (h < c_W) && (v < c_H);
        o.de = vis;
        o.r  = vis ? hx[3:0] : 4'h0;
        o.g  = vis ? vx[3:0] : 4'h0;
        o.b  = vis ? 4'h5    : 4'h0;
        o.hs = (h >= c_W + c_HFP && h < c_W + c_HFP + c_HS) ? c_HPOL : ~c_HPOL;
        o.vs = (v >= c_H + c_VFP && v < c_H + c_VFP + c_VS) ? c_VPOL : ~c_VPOL;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    // ------------------------------------------------------------------------
    // Period / width measurements, scaled by the enable gap
    // ------------------------------------------------------------------------
    int gap     = 1;
    bit meas    = 1'b0;
    int last_fs = -1;
    int last_ls = -1;
    int hs_run  = 0;
    int vs_run  = 0;
    bit hs_ok   = 1'b0;
    bit vs_ok   = 1'b0;
    bit seen_fs = 1'b0;

    task automatic reset_meas();
        last_fs = -1;
        last_ls = -1;
        hs_run  = 0;
        vs_run  = 0;
        hs_ok   = 1'b0;
        vs_ok   = 1'b0;
    endtask

    task automatic measure(input out_t o);
        if (o.fs) begin
            if (last_fs >= 0 && meas) check_val("fs_period", 64'(cyc - last_fs), 64'(c_LINE * c_FRAME * gap));
            last_fs = cyc;
        end
        if (o.ls) begin
            if (last_ls >= 0 && meas) check_val("ls_period", 64'(cyc - last_ls), 64'(c_LINE * gap));
            last_ls = cyc;
        end
        if (o.hs == c_HPOL) begin
            hs_run++;
        end else begin
            if (hs_run > 0 && hs_ok) check_val("hs_width", 64'(hs_run), 64'(c_HS * gap));
            hs_run = 0;
            hs_ok  = meas;
        end
        if (o.vs == c_VPOL) begin
            vs_run++;
        end else begin
            if (vs_run > 0 && vs_ok) check_val("vs_width", 64'(vs_run), 64'(c_VS * c_LINE * gap));
            vs_run = 0;
            vs_ok  = meas;
        end
    endtask

    // One clock: drive inputs at negedge, check, then advance the model at
    // the following posedge.
    task automatic step(input logic rst_v, input logic en_v);
        out_t        got;
        logic        vis;
        logic [32:0] pexp;
        @(negedge clk);
        rst = rst_v;
        en  = en_v;
        #1;
        seen_fs = 1'b0;
        if (started) begin
            got = {vga_de, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, line_start, frame_start};
            check_val("out", got, exp_out);
            vis  = (mh < c_W) && (mv < c_H);
            pexp = {vis && !rst_v, vis ? 16'(mh) : 16'd0, vis ? 16'(mv) : 16'd0};
            check_val("pix", {pix_req, pix_x, pix_y}, pexp);
            measure(got);
            seen_fs = got.fs;
        end
        @(posedge clk);
        if (rst_v) begin
            mh = 0;
            mv = 0;
            sb_q.delete();
            for (int i = 0; i < c_LAT; i++) sb_q.push_back(blank_out());
            exp_out = blank_out();
            started = 1'b1;
            reset_meas();
        end else if (en_v) begin
            sb_q.push_back(pos_out(mh, mv));
            exp_out = sb_q.pop_front();
            mh++;
            if (mh == c_LINE) begin
                mh = 0;
                mv++;
                if (mv == c_FRAME) mv = 0;
            end
        end else begin
            exp_out.ls = 1'b0;
            exp_out.fs = 1'b0;
        end
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int  lat;
        bit  found;
        force_ff = 1'b1;

        // Reset with en high and the colour input forced to all ones.
        repeat (3) step(1'b1, 1'b1);
        force_ff = 1'b0;

        // Free-running at full pixel rate.
        gap  = 1;
        meas = 1'b1;
        reset_meas();
        repeat (260) step(1'b0, 1'b1);

        // One enabled tick in four.
        gap = 4;
        reset_meas();
        for (int i = 0; i < 1000; i++) step(1'b0, (i % 4) == 3);

        // Mid-frame reset at (5,2).
        gap = 1;
        reset_meas();
        for (int i = 0; i < 200 && !(mh == 5 && mv == 2); i++) step(1'b0, 1'b1);
        check_val("seek_pos", {31'd0, mh == 5, 31'd0, mv == 2}, {31'd0, 1'b1, 31'd0, 1'b1});
        step(1'b1, 1'b1);
        lat   = -1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1);
            if (seen_fs) begin
                lat   = i;
                found = 1'b1;
            end
        end
        check_val("fs_latency", 64'(lat), 64'(c_LAT + 1));
        repeat (250) step(1'b0, 1'b1);

        // A few idle cycles: everything holds, strobes stay low.
        repeat (5) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
